// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline stages.
package mips_pkg;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int OPCODE_W = 6;
  localparam int FUNCT_W = 6;
  localparam int JUMP_INDEX_W = 26;
  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats load, neither means hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_plus4,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      if_id_instruction <= NOP_WORD;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_instruction <= instruction;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, next-PC mux, RUN/HALTED FSM and IF/ID register of the fetch stage.
// FETCH_PERF_COUNTERS_EN adds the fetch_count and stall_count ports.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  input  logic [31:0] instruction,
  output logic [31:0] read_address,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_misaligned
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  fetch_state_t state, state_next;
  logic [31:0] pc, pc_next, pc_plus4, target;
  logic run, redirect, load, flush, misaligned_next;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
      pc <= RESET_PC;
      fetch_misaligned <= 1'b0;
    end else begin
      state <= state_next;
      pc <= pc_next;
      fetch_misaligned <= misaligned_next;
    end
  end
  // Jump outranks branch, so a misaligned branch under a jump is not reported.
  always_comb begin
    run = state == RUN;
    state_next = (run && halt) ? HALTED : state;
    redirect = run && (jump || branch_taken);
    target = jump ? {if_id_pc_plus4[31:28], jump_index, 2'b00} : {branch_target[31:2], 2'b00};
    misaligned_next = run && !jump && branch_taken && (branch_target[1:0] != 2'b00);
    pc_plus4 = pc + 32'd4;
    load = run && !redirect && !stall;
    flush = !run || redirect;
    pc_next = redirect ? target : load ? pc_plus4 : pc;
  end
  assign read_address = pc;
  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clock(clock),
    .reset_n(reset_n),
    .load(load),
    .flush(flush),
    .instruction(instruction),
    .pc_plus4(pc_plus4),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid)
  );
`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      fetch_count <= fetch_count + {31'd0, load};
      stall_count <= stall_count + {31'd0, run && stall && !redirect};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;
  logic clock = 1'b0, reset_n = 1'b0, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, halt = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [25:0] jump_index = 26'd0;
  logic [31:0] instruction, read_address, if_id_instruction, if_id_pc_plus4;
  logic if_id_valid, fetch_misaligned;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count;
`endif
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pp4;
    logic v;
    logic mis;
  } exp_t;
  exp_t sb[$];
  exp_t e, g;
  int checks = 0, errors = 0;
  logic [31:0] m_pc = 32'd0, m_ins = 32'd0, m_pp4 = 32'd0, m_fc = 32'd0, m_sc = 32'd0, tgt, frozen;
  logic m_v = 1'b0, m_mis = 1'b0, m_halted = 1'b0;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index), .halt(halt),
    .instruction(instruction), .read_address(read_address), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid), .fetch_misaligned(fetch_misaligned)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'd0 ? 32'h2008_0005 : {a[15:0], ~a[31:16]};
  endfunction
  assign instruction = mem(read_address);

  function automatic exp_t cur();
    return '{read_address, if_id_instruction, if_id_pc_plus4, if_id_valid, fetch_misaligned};
  endfunction

  task automatic drive(input logic rn, st, br, j, h, input logic [31:0] bt, input logic [25:0] ji);
    reset_n = rn; stall = st; branch_taken = br; jump = j; halt = h;
    branch_target = bt; jump_index = ji;
    if (!rn) begin
      m_pc = 32'd0; m_ins = 32'd0; m_pp4 = 32'd0; m_v = 0; m_mis = 0; m_halted = 0;
      m_fc = 32'd0; m_sc = 32'd0;
    end else if (m_halted) begin
      m_ins = 32'd0; m_pp4 = 32'd0; m_v = 0; m_mis = 0;
    end else begin
      m_mis = !j && br && bt[1:0] != 2'b00;
      if (j || br) begin
        tgt = j ? {m_pp4[31:28], ji, 2'b00} : (bt & 32'hFFFF_FFFC);
        m_pc = tgt; m_ins = 32'd0; m_pp4 = 32'd0; m_v = 0;
      end else if (st) begin
        m_sc = m_sc + 1;
      end else begin
        m_ins = mem(m_pc); m_pp4 = m_pc + 32'd4; m_v = 1; m_pc = m_pc + 32'd4;
        m_fc = m_fc + 1;
      end
      if (h) m_halted = 1;
    end
    sb.push_back('{m_pc, m_ins, m_pp4, m_v, m_mis});
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      e = sb.pop_front(); g = cur(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_state: got %h want %h", g, e); end
    end
    checks++;
    if (read_address !== 32'd0 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pc: got %h/%b want 0/0", read_address, if_id_valid);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e) begin errors++; $display("FAIL first_fetch: got %h want %h", g, e); end
    checks++;
    if (if_id_instruction !== 32'h2008_0005 || if_id_pc_plus4 !== 32'd4 || read_address !== 32'd4) begin
      errors++; $display("FAIL first_fetch_abs: got %h %h %h", if_id_instruction, if_id_pc_plus4, read_address);
    end
  endtask

  task automatic test_stall();
    logic [31:0] sc0;
    drive(1, 0, 0, 0, 0, 0, 0);
`ifdef FETCH_PERF_COUNTERS_EN
    sc0 = stall_count;
`else
    sc0 = 32'd0;
`endif
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0);
      e = sb.pop_front(); g = cur(); checks++;
      if (g !== e || read_address !== 32'd8) begin
        errors++; $display("FAIL stall_%0d: got %h want %h", i, g, e);
      end
    end
`ifdef FETCH_PERF_COUNTERS_EN
    checks++;
    if (stall_count - sc0 !== 32'd3) begin
      errors++; $display("FAIL stall_count: got %0d want 3", stall_count - sc0);
    end
`endif
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    drive(1, 0, 1, 0, 0, 32'h40, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'h40 || if_id_valid !== 1'b0) begin
      errors++; $display("FAIL branch_redirect: got %h want %h", g, e);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || if_id_pc_plus4 !== 32'h44 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL branch_target_fetch: got %h want %h", g, e);
    end
  endtask

  task automatic test_jump();
    drive(1, 0, 1, 0, 0, 32'h1000_0004, 0);
    e = sb.pop_front();
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || if_id_pc_plus4 !== 32'h1000_0008) begin
      errors++; $display("FAIL jump_setup: got %h want %h", g, e);
    end
    drive(1, 1, 1, 1, 0, 32'h0000_0203, 26'h10);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'h1000_0040 || if_id_valid !== 1'b0 || fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL jump_priority: got %h want %h", g, e);
    end
  endtask

  task automatic test_misaligned_wrap();
    drive(1, 0, 1, 0, 0, 32'h42, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'h40 || fetch_misaligned !== 1'b1) begin
      errors++; $display("FAIL misaligned_pulse: got %h want %h", g, e);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL misaligned_clear: got %h want %h", g, e);
    end
    drive(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
    e = sb.pop_front();
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'd0 || if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b1) begin
      errors++; $display("FAIL pc_wrap: got %h want %h", g, e);
    end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      e = sb.pop_front();
    end
    frozen = read_address;
    drive(1, 1, 0, 0, 1, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e) begin errors++; $display("FAIL halt_edge: got %h want %h", g, e); end
    for (int i = 0; i < 4; i++) begin
      drive(1, i[0], 1, i[1], 0, 32'h100, 26'h3);
      e = sb.pop_front(); g = cur(); checks++;
      if (g !== e || read_address !== frozen || if_id_valid !== 1'b0) begin
        errors++; $display("FAIL halted_%0d: got %h want %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    drive(1, 0, 1, 0, 0, 32'h80, 0);
    e = sb.pop_front();
    drive(1, 1, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'h80) begin
      errors++; $display("FAIL pre_reset: got %h want %h", g, e);
    end
    drive(0, 1, 1, 1, 1, 32'h33, 26'h7);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || read_address !== 32'd0 || if_id_valid !== 1'b0 || if_id_instruction !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got %h want %h", g, e);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL counters_reset: got %0d %0d want 0 0", fetch_count, stall_count);
    end
`endif
    drive(1, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front(); g = cur(); checks++;
    if (g !== e || if_id_instruction !== 32'h2008_0005) begin
      errors++; $display("FAIL post_reset_fetch: got %h want %h", g, e);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    checks++;
    if (fetch_count !== m_fc || stall_count !== m_sc) begin
      errors++; $display("FAIL counters_model: got %0d %0d want %0d %0d", fetch_count, stall_count, m_fc, m_sc);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_jump();
    test_misaligned_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue MIPS pipeline. Holds the program counter, drives `read_address` into `InstructionMemory`, and captures the returned `instruction` plus PC+4 into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect and halt. Feeds the decode stage directly.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `NOP_WORD`, 32'h0000_0000: instruction word inserted into IF/ID on flush or reset.
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `stall` in 1: hazard unit; holds PC and IF/ID.
- `branch_taken` in 1: redirect to `branch_target`; flushes IF/ID.
- `branch_target` in 32: full byte address.
- `jump` in 1: redirect to pseudo-direct jump target; flushes IF/ID.
- `jump_index` in 26: instr[25:0] of the jump in ID.
- `halt` in 1: stop fetching until reset.
- `instruction` in 32: from `InstructionMemory`; combinational w.r.t. `read_address`.
- `read_address` out 32: to `InstructionMemory`; equals the PC register.
- `if_id_instruction` out 32: registered instruction word.
- `if_id_pc_plus4` out 32: registered PC+4 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `fetch_misaligned` out 1: one-cycle pulse; redirect target had bits [1:0] ≠ 0.
- `fetch_count` out 32, `stall_count` out 32: present only with `FETCH_PERF_COUNTERS_EN`.

## Operation
- FSM with 2 states: RUN and HALTED. Reset goes to RUN. RUN goes to HALTED on a posedge where `halt`=1. HALTED stays until reset.
- Next-PC priority, evaluated in RUN: jump, then branch_taken, then stall (hold), then PC+4.
- Jump target = {`if_id_pc_plus4`[31:28], `jump_index`, 2'b00}.
- Redirect target bits [1:0] are forced to 0. If the raw `branch_target`[1:0] ≠ 0, pulse `fetch_misaligned`.
- `jump` and `branch_taken` both 1: jump wins. `fetch_misaligned` is evaluated on the jump target only, which is always aligned.
- Redirect loads the PC with the target and loads IF/ID with `NOP_WORD`, `if_id_valid`=0 and `if_id_pc_plus4`=0. Redirect overrides `stall` in the same cycle.
- Stall with no redirect: PC and IF/ID unchanged.
- Normal fetch: IF/ID ← {`instruction`, PC+4}, `if_id_valid`=1, PC ← PC+4. Arithmetic is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- HALTED: PC frozen. IF/ID ← `NOP_WORD` with valid=0 every cycle. `stall`, `jump` and `branch_taken` are ignored.

## Timing
- Reset values, applied at the posedge with `reset_n`=0:
  - PC = `RESET_PC`, hence `read_address` = `RESET_PC`.
  - `if_id_instruction` = `NOP_WORD`, `if_id_pc_plus4` = 0, `if_id_valid` = 0.
  - `fetch_misaligned` = 0, counters = 0, state = RUN.
- Reset asserted mid-operation overrides every other input at that edge.
- `read_address` is valid directly from the register, one clock-to-q after the edge.
- `instruction` is sampled at the next edge.
- Redirect asserted in cycle N:
  - `read_address` = target in N+1.
  - Target instruction is valid in IF/ID after edge N+1.
  - Exactly one slot is flushed.
- `fetch_misaligned` is registered and high for exactly the cycle after the offending edge.

## Configuration
- `FETCH_PERF_COUNTERS_EN` defined:
  - `fetch_count` increments on every edge that loads IF/ID with valid=1.
  - `stall_count` increments on every RUN edge with `stall`=1 and no redirect.
  - Both are 32-bit and wrap silently.
- Not defined: both ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package `mips_pkg`:
  - `NOP_WORD` default, `RESET_PC` default.
  - FSM state enum `fetch_state_t` {RUN, HALTED}.
  - Opcode width constants.
- One sub-module, `if_id_reg`: the IF/ID pipeline register with load, flush and hold controls. It is reused by the decode-stage owner for testing.
- Next-PC mux and FSM stay in `fetch_unit`.

## Test plan
- Reset then release, memory returns 32'h2008_0005 at address 0: `read_address`=0 while in reset. After the first edge, IF/ID = {32'h2008_0005, 4} with valid=1 and `read_address`=4.
- `stall` for 3 cycles at PC=8: `read_address` holds 8 and IF/ID is unchanged for 3 cycles. `stall_count` +3 when the macro is enabled.
- `branch_taken`=1, `branch_target`=32'h40 at PC=12: next cycle `read_address`=32'h40 and `if_id_valid`=0. Following edge loads IF/ID with pc_plus4=32'h44.
- `jump`=1 with `jump_index`=26'h10, `if_id_pc_plus4`=32'h1000_0008, plus simultaneous `branch_taken` and `stall`: `read_address`=32'h1000_0040 and IF/ID is flushed.
- `branch_target`=32'h42: PC becomes 32'h40 and `fetch_misaligned` pulses for one cycle. Then assert `halt`: PC frozen and `if_id_valid`=0 until `reset_n`=0.
- `reset_n` dropped mid-run at PC=32'h80 with `stall`=1: next edge gives PC=`RESET_PC`, IF/ID = NOP with valid=0, and counters = 0.
